// File: rtl/player_laser.sv
// Player laser projectile: spawns one upward-moving laser from the gun
// position, advances it once per frame, explodes on an enemy hit, and
// enforces a cooldown between shots.
// Optional build macro: PLAYER_LASER_HOLD_FIRE_EN (defined = holding the
// button auto-refires; undefined = button must be released between shots).
module player_laser #(
   parameter logic [11:0] color_p           = {4'hF, 4'hF, 4'hF},
   parameter int          width_p           = 4,
   parameter int          height_p          = 12,
   parameter int          speed_p           = 8,
   parameter int          spawn_y_p         = 440,
   parameter int          top_border_p      = 8,
   parameter int          explode_frames_p  = 6,
   parameter int          cooldown_frames_p = 10
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       frame_i,
   input  logic       shoot_i,
   input  logic       alive_i,
   input  logic       pause_i,
   input  logic       clear_i,
   input  logic [9:0] gun_left_i,
   input  logic [9:0] gun_right_i,
   input  logic       hit_enemy_i,
   output logic       fired_o,
   output logic       laser_active_o,
   output logic       exploding_o,
   output logic [9:0] laser_left_o,
   output logic [9:0] laser_right_o,
   output logic [9:0] laser_top_o,
   output logic [9:0] laser_bot_o,
   output logic [3:0] laser_red_o,
   output logic [3:0] laser_green_o,
   output logic [3:0] laser_blue_o,
   output logic [2:0] state_o
);

   localparam logic [2:0] ST_IDLE = 3'b001;
   localparam logic [2:0] ST_FLY  = 3'b010;
   localparam logic [2:0] ST_EXP  = 3'b100;

   localparam int         CNT_W    = 8;
   localparam logic [CNT_W-1:0] EXPL_N = CNT_W'(explode_frames_p);
   localparam logic [CNT_W-1:0] CD_N   = CNT_W'(cooldown_frames_p);
   localparam logic [9:0] SPAWN_Y  = 10'(spawn_y_p);
   localparam logic [9:0] SPEED    = 10'(speed_p);
   localparam logic [9:0] MISS_LIM = 10'(top_border_p + speed_p);
   localparam logic [9:0] HALF_W   = 10'(width_p / 2);
   localparam logic [9:0] W_M1     = 10'(width_p - 1);
   localparam logic [9:0] H_M1     = 10'(height_p - 1);

   // Counts down to zero and stays there.
   function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
      return (v == '0) ? '0 : v - CNT_W'(1);
   endfunction

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cool_q, cool_d;
   logic [CNT_W-1:0] expl_q, expl_d;
   logic [9:0]       left_q, left_d;
   logic [9:0]       right_q, right_d;
   logic [9:0]       top_q, top_d;
   logic             fired_q, fired_d;
   logic             armed;
   logic             fire;
   logic [9:0]       mid;

`ifdef PLAYER_LASER_HOLD_FIRE_EN
   assign armed = 1'b1;
`else
   // shoot_q = button still held since the last shot; the trigger re-arms
   // once shoot_i is seen low.
   logic shoot_q, shoot_d;
   assign armed = ~shoot_q;
`endif

   // Gun centre; the sum needs 11 bits before halving.
   assign mid  = 10'(({1'b0, gun_left_i} + {1'b0, gun_right_i}) >> 1);
   assign fire = frame_i & shoot_i & alive_i & ~pause_i & (cool_q == '0) & armed;

   // Next-state, counter and position logic.
   always_comb begin
      state_d = state_q;
      cool_d  = cool_q;
      expl_d  = expl_q;
      left_d  = left_q;
      right_d = right_q;
      top_d   = top_q;
      fired_d = 1'b0;
`ifndef PLAYER_LASER_HOLD_FIRE_EN
      shoot_d = shoot_q;
`endif
      if (clear_i) begin
         state_d = ST_IDLE;
         cool_d  = '0;
         expl_d  = '0;
         left_d  = '0;
         right_d = '0;
         top_d   = SPAWN_Y;
`ifndef PLAYER_LASER_HOLD_FIRE_EN
         shoot_d = 1'b0;
`endif
      end else if (state_q != ST_IDLE && state_q != ST_FLY && state_q != ST_EXP) begin
         state_d = ST_IDLE;
      end else if (!pause_i) begin
`ifndef PLAYER_LASER_HOLD_FIRE_EN
         if (!shoot_i) shoot_d = 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (frame_i) cool_d = sat_dec(cool_q);
               if (fire) begin
                  state_d = ST_FLY;
                  left_d  = mid - HALF_W;
                  right_d = mid - HALF_W + W_M1;
                  top_d   = SPAWN_Y;
                  fired_d = 1'b1;
`ifndef PLAYER_LASER_HOLD_FIRE_EN
                  shoot_d = 1'b1;
`endif
               end
            end
            ST_FLY: begin
               // A hit outranks the frame step, including the border miss.
               if (hit_enemy_i) begin
                  state_d = ST_EXP;
                  expl_d  = EXPL_N;
               end else if (frame_i) begin
                  if (top_q < MISS_LIM) begin
                     state_d = ST_IDLE;
                     cool_d  = CD_N;
                  end else begin
                     top_d = top_q - SPEED;
                  end
               end
            end
            default: begin
               if (frame_i) begin
                  expl_d = sat_dec(expl_q);
                  if (expl_q <= CNT_W'(1)) begin
                     state_d = ST_IDLE;
                     cool_d  = CD_N;
                  end
               end
            end
         endcase
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= ST_IDLE;
         cool_q  <= '0;
         expl_q  <= '0;
         left_q  <= '0;
         right_q <= '0;
         top_q   <= SPAWN_Y;
         fired_q <= 1'b0;
`ifndef PLAYER_LASER_HOLD_FIRE_EN
         shoot_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cool_q  <= cool_d;
         expl_q  <= expl_d;
         left_q  <= left_d;
         right_q <= right_d;
         top_q   <= top_d;
         fired_q <= fired_d;
`ifndef PLAYER_LASER_HOLD_FIRE_EN
         shoot_q <= shoot_d;
`endif
      end
   end

   // fired_o pulses on the first cycle the new laser is visible.
   assign fired_o        = fired_q;
   assign laser_active_o = (state_q == ST_FLY);
   assign exploding_o    = (state_q == ST_EXP);
   assign laser_left_o   = left_q;
   assign laser_right_o  = right_q;
   assign laser_top_o    = top_q;
   assign laser_bot_o    = top_q + H_M1;
   assign laser_red_o    = color_p[11:8];
   assign laser_green_o  = color_p[7:4];
   assign laser_blue_o   = color_p[3:0];
   assign state_o        = state_q;

endmodule
